// File: rtl/prog_loader.sv
// prog_loader: boot-time instruction-memory loader.
// Receives a framed byte stream (SYNC, LEN_HI, LEN_LO, N big-endian words, CHK) over a
// valid/ready handshake. It writes word i to byte address 2*i and keeps the CPU in reset
// until a frame with a good checksum has been loaded.
// Ports:
//   clk, reset      - clock; asynchronous active-low reset
//   rx_data/valid   - incoming byte stream
//   rx_ready        - byte accepted on posedge when rx_valid & rx_ready
//   imem_we/addr/   - one-cycle instruction-memory write strobe, byte address, data
//   imem_wdata
//   cpu_reset       - active-high CPU reset, released only after a good load
//   done, err       - load complete / frame rejected
module prog_loader #(
  parameter int unsigned DEPTH = 256,
  parameter logic [7:0]  SYNC  = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    StIdle, StLenHi, StLenLo, StDataHi, StDataLo, StCheck, StDone, StError
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  xor_q, xor_d;
  logic [7:0]  hi_q, hi_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;

  logic        accept;
  logic [15:0] len_rx;

  assign rx_ready = (state_q != StDone);
  assign accept   = rx_valid & rx_ready;
  // Full length as it becomes known while the LEN_LO byte is on the bus.
  assign len_rx   = {len_q[15:8], rx_data};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    xor_d   = xor_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      unique case (state_q)
        StIdle, StError: begin
          if (rx_data == SYNC) begin
            cnt_d   = '0;
            xor_d   = '0;
            state_d = StLenHi;
          end
        end
        StLenHi: begin
          len_d   = {rx_data, 8'h00};
          xor_d   = xor_q ^ rx_data;
          state_d = StLenLo;
        end
        StLenLo: begin
          len_d = len_rx;
          xor_d = xor_q ^ rx_data;
          if (32'(len_rx) > DEPTH) begin
            state_d = StError;
          end else if (len_rx == 16'd0) begin
            state_d = StCheck;
          end else begin
            state_d = StDataHi;
          end
        end
        StDataHi: begin
          hi_d    = rx_data;
          xor_d   = xor_q ^ rx_data;
          state_d = StDataLo;
        end
        StDataLo: begin
          we_d    = 1'b1;
          addr_d  = {cnt_q[14:0], 1'b0};
          wdata_d = {hi_q, rx_data};
          cnt_d   = cnt_q + 16'd1;
          xor_d   = xor_q ^ rx_data;
          state_d = (cnt_q + 16'd1 == len_q) ? StCheck : StDataHi;
        end
        StCheck: begin
          state_d = (rx_data == xor_q) ? StDone : StError;
        end
        StDone: begin
          state_d = StDone;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      xor_q   <= '0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      xor_q   <= xor_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign done       = (state_q == StDone);
  assign err        = (state_q == StError);
  assign cpu_reset  = (state_q != StDone);

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        err;

  prog_loader #(
    .DEPTH(256),
    .SYNC (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Write log sampled mid-cycle; a one-cycle strobe is seen exactly once.
  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  end

  typedef struct {
    bit          pre_rst;
    bit          valid;
    logic [7:0]  data;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          dn;
    bit          er;
    bit          cr;
    bit          rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit val, logic [7:0] d, bit we, logic [15:0] a,
                              logic [15:0] w, bit dn, bit er, bit cr, bit rd);
    vec_t v;
    v.pre_rst = r; v.valid = val; v.data = d; v.we = we; v.addr = a; v.wdata = w;
    v.dn = dn; v.er = er; v.cr = cr; v.rd = rd;
    return v;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, " rx_ready"}, 16'(rx_ready), 16'd1);
    chk({tag, " imem_we"}, 16'(imem_we), 16'd0);
    chk({tag, " imem_addr"}, imem_addr, 16'h0000);
    chk({tag, " imem_wdata"}, imem_wdata, 16'h0000);
    chk({tag, " cpu_reset"}, 16'(cpu_reset), 16'd1);
    chk({tag, " done"}, 16'(done), 16'd0);
    chk({tag, " err"}, 16'(err), 16'd0);
  endtask

  // Called at a negedge; asserts reset between edges, releases at a later negedge.
  task automatic pulse_reset();
    rx_valid = 1'b0;
    #2 reset = 1'b0;
    #1 chk_reset_outputs("async reset");
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Called at a negedge; leaves at a negedge after the byte is consumed.
  task automatic send_byte(logic [7:0] b, int gap);
    for (int i = 0; i < gap; i++) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic chk_basic_writes(string tag, int base);
    chk({tag, " write count"}, 16'(wr_addr.size()), 16'(base + 2));
    if (wr_addr.size() == base + 2) begin
      chk({tag, " w0 addr"}, wr_addr[base], 16'h0000);
      chk({tag, " w0 data"}, wr_data[base], 16'h1234);
      chk({tag, " w1 addr"}, wr_addr[base + 1], 16'h0002);
      chk({tag, " w1 data"}, wr_data[base + 1], 16'hABCD);
    end
  endtask

  logic [7:0] basic[8];

  initial begin
    basic = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Basic load
    vecs.push_back(mk(1, 1, 8'hA5, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h02, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h12, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h34, 1, 16'h0000, 16'h1234, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 8'hEE, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'hAB, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'hCD, 1, 16'h0002, 16'hABCD, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h42, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'hA5, 0, 0, 0, 1, 0, 0, 0));
    // Bad checksum, then recovery with an empty frame
    vecs.push_back(mk(1, 1, 8'hA5, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h02, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h12, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h34, 1, 16'h0000, 16'h1234, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'hAB, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'hCD, 1, 16'h0002, 16'hABCD, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h43, 0, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 1, 8'h77, 0, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 1, 8'hA5, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h00, 0, 0, 0, 1, 0, 0, 0));
    // Empty frame from reset
    vecs.push_back(mk(1, 1, 8'hA5, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h00, 0, 0, 0, 1, 0, 0, 0));
    // Oversize: N = 257
    vecs.push_back(mk(1, 1, 8'hA5, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h01, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h01, 0, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 1, 8'h12, 0, 0, 0, 0, 1, 1, 1));
    // N = DEPTH exactly is accepted
    vecs.push_back(mk(1, 1, 8'hA5, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h01, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h12, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h34, 1, 16'h0000, 16'h1234, 0, 0, 1, 1));

    #3 chk_reset_outputs("initial reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      if (vecs[i].pre_rst) pulse_reset();
      rx_valid = vecs[i].valid;
      rx_data  = vecs[i].data;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d imem_we", i), 16'(imem_we), 16'(vecs[i].we));
      if (vecs[i].we) begin
        chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].addr);
        chk($sformatf("v%0d imem_wdata", i), imem_wdata, vecs[i].wdata);
      end
      chk($sformatf("v%0d done", i), 16'(done), 16'(vecs[i].dn));
      chk($sformatf("v%0d err", i), 16'(err), 16'(vecs[i].er));
      chk($sformatf("v%0d cpu_reset", i), 16'(cpu_reset), 16'(vecs[i].cr));
      chk($sformatf("v%0d rx_ready", i), 16'(rx_ready), 16'(vecs[i].rd));
      @(negedge clk);
    end

    // Resync past garbage, basic frame with random gaps
    pulse_reset();
    wr_addr.delete();
    wr_data.delete();
    send_byte(8'h00, 0);
    send_byte(8'hFF, 1);
    send_byte(8'h5A, 0);
    foreach (basic[i]) send_byte(basic[i], int'($urandom_range(0, 3)));
    chk("resync done", 16'(done), 16'd1);
    chk("resync cpu_reset", 16'(cpu_reset), 16'd0);
    chk_basic_writes("resync", 0);

    // Reset asserted mid-frame, just as the low byte 0xCD is presented
    pulse_reset();
    wr_addr.delete();
    wr_data.delete();
    for (int i = 0; i < 6; i++) send_byte(basic[i], 0);
    rx_valid = 1'b1;
    rx_data  = 8'hCD;
    #2 reset = 1'b0;
    #1 chk_reset_outputs("mid-frame reset");
    @(posedge clk);
    #1 chk("held reset imem_we", 16'(imem_we), 16'd0);
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b1;
    chk("mid-frame write count", 16'(wr_addr.size()), 16'd1);
    @(negedge clk);
    foreach (basic[i]) send_byte(basic[i], 0);
    chk("reload done", 16'(done), 16'd1);
    chk("reload err", 16'(err), 16'd0);
    chk_basic_writes("reload", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
